rom_stream_reader: RTL

Initiator/reader for the on-chip synchronous boot ROM (32-bit words, 1-cycle registered read). On a start command it reads a contiguous run of words and presents them on a valid/ready output stream. Typical consumers are a RAM preloader or a flash/SPI copy engine. It owns the ROM address bus, absorbs the ROM's fixed read latency, and sustains 1 word/cycle under continuous ready.

---
 rtl/rom_stream_reader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// Boot-ROM stream reader: issues sequential reads from a 1-cycle synchronous ROM
// and presents the words on a valid/ready stream through a 2-entry skid FIFO.
module rom_stream_reader #(
    parameter int MEM_WORDS = 8192,
    parameter int ADR_WIDTH = 13,
    parameter int CNT_WIDTH = 14
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 start,
    input  logic [ADR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 rom_en,
    output logic [ADR_WIDTH-1:0] rom_addr,
    input  logic [31:0]          rom_do,
    output logic                 m_valid,
    output logic [31:0]          m_data,
    output logic                 m_last,
    input  logic                 m_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADR_WIDTH-1:0] r_addr;
    logic [ADR_WIDTH-1:0] r_addr_hold;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic                 r_inflight;
    logic                 r_inflight_last;
    logic                 r_done;
    logic [1:0][31:0]     r_fifo_data;
    logic [1:0]           r_fifo_last;
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_occ;

    logic                 w_pop;
    logic                 w_issue;
    logic [2:0]           w_occ_after;
    logic                 w_accept;
    logic                 w_zero_start;
    logic                 w_last_pop;
    logic                 w_rem_one;
    logic [ADR_WIDTH-1:0] w_addr_nxt;

    // Handshake, issue decision and address/count helpers
    always_comb begin
        w_pop        = m_valid && m_ready;
        // Words that will still be held after this cycle; a new read may only
        // go out if it leaves room for the one it will bring back.
        w_occ_after  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rem_one    = (r_remaining == CNT_WIDTH'(1));
        w_issue      = (r_state == S_RUN) && (r_remaining != {CNT_WIDTH{1'b0}})
                       && (w_occ_after <= 3'd1);
        w_accept     = (r_state == S_IDLE) && start && (word_count != {CNT_WIDTH{1'b0}});
        w_zero_start = (r_state == S_IDLE) && start && (word_count == {CNT_WIDTH{1'b0}});
        w_last_pop   = (r_state == S_DRAIN) && w_pop && m_last;
        if (r_addr == ADR_WIDTH'(MEM_WORDS - 1)) begin
            w_addr_nxt = {ADR_WIDTH{1'b0}};
        end else begin
            w_addr_nxt = r_addr + ADR_WIDTH'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_issue && w_rem_one) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, address/count sequencing and in-flight tracking
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_addr          <= {ADR_WIDTH{1'b0}};
            r_addr_hold     <= {ADR_WIDTH{1'b0}};
            r_remaining     <= {CNT_WIDTH{1'b0}};
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= w_zero_start || w_last_pop;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_rem_one;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= word_count;
            end else if (w_issue) begin
                r_addr      <= w_addr_nxt;
                r_remaining <= r_remaining - CNT_WIDTH'(1);
                r_addr_hold <= r_addr;
            end else begin
                r_addr      <= r_addr;
                r_remaining <= r_remaining;
            end
        end
    end

    // Two-entry FIFO: unconditional capture of the landing ROM word
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_fifo_data <= {2{32'h0000_0000}};
            r_fifo_last <= 2'b00;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wptr] <= rom_do;
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end else begin
                r_rptr <= r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Output decode from registered state
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = r_done;
        rom_en   = w_issue;
        rom_addr = w_issue ? r_addr : r_addr_hold;
        m_valid  = (r_occ != 2'd0);
        m_data   = r_fifo_data[r_rptr];
        m_last   = m_valid && r_fifo_last[r_rptr];
    end

endmodule
